// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the pipelined adder datapath.
package pipelined_adder_pkg;

   // Two's-complement overflow: the carry into the sign bit disagrees with the carry out of it.
   function automatic logic signed_ovf(input logic c_into_msb, input logic c_out_msb);
      return c_into_msb ^ c_out_msb;
   endfunction

endpackage

// File: rtl/ripple_adder.sv
// Combinational ripple-carry adder; used as one pipeline slice of pipelined_adder.
module ripple_adder #(
   parameter int N_WIDTH = 8
) (
   input  logic [N_WIDTH-1:0] a_i,
   input  logic [N_WIDTH-1:0] b_i,
   input  logic               c_i,
   output logic [N_WIDTH-1:0] sum_o,
   output logic               c_o
);
   logic [N_WIDTH:0] carry;

   assign carry[0] = c_i;

   generate
      for (genvar gi = 0; gi < N_WIDTH; gi++) begin : g_bit
         assign sum_o[gi]   = a_i[gi] ^ b_i[gi] ^ carry[gi];
         assign carry[gi+1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
      end
   endgenerate

   assign c_o = carry[N_WIDTH];
endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract split into STAGES equal slices, one slice per stage with the carry registered between
// stages; a single global advance enable gives valid/ready flow control with backpressure.
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int N_WIDTH = 16,
   parameter int STAGES  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N_WIDTH-1:0] in_a,
   input  logic [N_WIDTH-1:0] in_b,
   input  logic               in_c,
   input  logic               in_sub,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N_WIDTH-1:0] out_sum,
   output logic               out_c,
   output logic               out_ovf
);
   localparam int STAGES_SAFE = (STAGES < 1) ? 1 : STAGES;
   localparam int SLICE_W     = N_WIDTH / STAGES_SAFE;

   generate
      if (STAGES < 1 || (N_WIDTH % STAGES_SAFE) != 0) begin : g_bad_params
         $error("pipelined_adder: N_WIDTH (%0d) must be a positive multiple of STAGES (%0d)",
                N_WIDTH, STAGES);
      end
   endgenerate

   logic               adv;
   logic [N_WIDTH-1:0] b_eff;
   logic               c_eff;

   // Stage inputs (previous stage registers, or the ports for stage 0) and next-state values.
   logic               v_in  [STAGES_SAFE];
   logic [N_WIDTH-1:0] a_in  [STAGES_SAFE];
   logic [N_WIDTH-1:0] b_in  [STAGES_SAFE];
   logic               cy_in [STAGES_SAFE];
   logic [N_WIDTH-1:0] s_in  [STAGES_SAFE];
   logic [N_WIDTH-1:0] sum_d [STAGES_SAFE];
   logic               c_d   [STAGES_SAFE];
   logic               ovf_d;

   logic               v_q   [STAGES_SAFE];
   logic [N_WIDTH-1:0] a_q   [STAGES_SAFE];
   logic [N_WIDTH-1:0] b_q   [STAGES_SAFE];
   logic [N_WIDTH-1:0] sum_q [STAGES_SAFE];
   logic               c_q   [STAGES_SAFE];
   logic               ovf_q;

   assign adv   = !v_q[STAGES_SAFE-1] || out_ready;
   assign b_eff = in_sub ? ~in_b : in_b;
   assign c_eff = in_sub ? ~in_c : in_c;

   generate
      for (genvar gi = 0; gi < STAGES_SAFE; gi++) begin : g_stage
         localparam int                 LSB        = gi * SLICE_W;
         localparam logic [N_WIDTH-1:0] SLICE_MASK = N_WIDTH'({SLICE_W{1'b1}}) << LSB;

         logic [SLICE_W-1:0] slice_sum;
         logic               slice_c;

         if (gi == 0) begin : g_head
            assign v_in[gi]  = in_valid;
            assign a_in[gi]  = in_a;
            assign b_in[gi]  = b_eff;
            assign cy_in[gi] = c_eff;
            assign s_in[gi]  = '0;
         end else begin : g_body
            assign v_in[gi]  = v_q[gi-1];
            assign a_in[gi]  = a_q[gi-1];
            assign b_in[gi]  = b_q[gi-1];
            assign cy_in[gi] = c_q[gi-1];
            assign s_in[gi]  = sum_q[gi-1];
         end

         ripple_adder #(
            .N_WIDTH(SLICE_W)
         ) u_slice (
            .a_i  (a_in[gi][LSB +: SLICE_W]),
            .b_i  (b_in[gi][LSB +: SLICE_W]),
            .c_i  (cy_in[gi]),
            .sum_o(slice_sum),
            .c_o  (slice_c)
         );

         assign sum_d[gi] = (s_in[gi] & ~SLICE_MASK) | (N_WIDTH'(slice_sum) << LSB);
         assign c_d[gi]   = slice_c;

         // Carry into the MSB is recovered from the sum bit rather than exported by the slice.
         if (gi == STAGES_SAFE - 1) begin : g_tail
            logic c_msb;
            assign c_msb = slice_sum[SLICE_W-1] ^ a_in[gi][N_WIDTH-1] ^ b_in[gi][N_WIDTH-1];
            assign ovf_d = signed_ovf(c_msb, slice_c);
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES_SAFE; k++) begin
            v_q[k]   <= 1'b0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
            c_q[k]   <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < STAGES_SAFE; k++) begin
            v_q[k]   <= v_in[k];
            a_q[k]   <= a_in[k];
            b_q[k]   <= b_in[k];
            sum_q[k] <= sum_d[k];
            c_q[k]   <= c_d[k];
         end
         ovf_q <= ovf_d;
      end
   end

   assign in_ready  = adv;
   assign out_valid = v_q[STAGES_SAFE-1];
   assign out_sum   = sum_q[STAGES_SAFE-1];
   assign out_c     = c_q[STAGES_SAFE-1];
   assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder at N_WIDTH=8, STAGES=2.
module tb_pipelined_adder;
   localparam int N  = 8;
   localparam int ST = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_a;
   logic [N-1:0] in_b;
   logic         in_c;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_sum;
   logic         out_c;
   logic         out_ovf;

   pipelined_adder #(
      .N_WIDTH(N),
      .STAGES (ST)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_c     (in_c),
      .in_sub   (in_sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_c    (out_c),
      .out_ovf  (out_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] sum;
      logic         c;
      logic         ovf;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp   = 0;
   int   n_err   = 0;
   int   n_pop   = 0;
   int   cyc     = 0;
   bit   rand_rdy = 1'b0;
   bit   chk_lat  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic c, input logic sub);
      exp_t         r;
      logic [N-1:0] be;
      logic         ce;
      logic [N:0]   full;
      be     = sub ? ~b : b;
      ce     = sub ? ~c : c;
      full   = {1'b0, a} + {1'b0, be} + {{N{1'b0}}, ce};
      r.sum  = full[N-1:0];
      r.c    = full[N];
      r.ovf  = (a[N-1] == be[N-1]) && (r.sum[N-1] != a[N-1]);
      r.cyc  = 0;
      return r;
   endfunction

   // Call at posedge+1; returns at posedge+1 after the accepting edge with in_valid still high.
   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                       input logic sub, input exp_t e);
      bit ok = 1'b0;
      in_a = a; in_b = b; in_c = c; in_sub = sub; in_valid = 1'b1;
      for (int t = 0; t < 500 && !ok; t++) begin
         @(negedge clk);
         if (in_ready) begin
            e.cyc = cyc;
            sb.push_back(e);
            ok = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      check("accepted", 32'(ok), 32'd1);
      $display("send a=%02h b=%02h c=%0d sub=%0d exp sum=%02h c=%0d ovf=%0d",
               a, b, c, sub, e.sum, e.c, e.ovf);
   endtask

   task automatic drain();
      for (int t = 0; t < 400 && sb.size() != 0; t++) @(negedge clk);
      check("drain_empty", 32'(sb.size()), 32'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Random backpressure source.
   initial forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Output monitor: handshake rule, stall stability, in-order scoreboard compare.
   initial begin
      exp_t         e;
      bit           prev_stall = 1'b0;
      logic [N-1:0] prev_sum   = '0;
      logic         prev_c     = 1'b0;
      logic         prev_ovf   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb.delete();
            prev_stall = 1'b0;
         end else begin
            check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (prev_stall) begin
               check("hold_valid", 32'(out_valid), 32'd1);
               check("hold_sum", 32'(out_sum), 32'(prev_sum));
               check("hold_c", 32'(out_c), 32'(prev_c));
               check("hold_ovf", 32'(out_ovf), 32'(prev_ovf));
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_out", 32'(out_valid), 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("sum", 32'(out_sum), 32'(e.sum));
                  check("c", 32'(out_c), 32'(e.c));
                  check("ovf", 32'(out_ovf), 32'(e.ovf));
                  if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'(ST));
                  n_pop++;
                  $display("recv sum=%02h c=%0d ovf=%0d", out_sum, out_c, out_ovf);
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = out_sum;
            prev_c     = out_c;
            prev_ovf   = out_ovf;
         end
      end
   end

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         c;
      logic         sub;
      logic [N-1:0] sum;
      logic         co;
      logic         ovf;
   } vec_t;

   initial begin
      vec_t         dir[$];
      logic [N-1:0] corner[6];
      exp_t         e;
      int           p0;
      logic [N-1:0] ra, rb;
      logic         rc, rs;

      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = 1'b0; in_sub = 1'b0;
      out_ready = 1'b1;

      #7;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sum", 32'(out_sum), 32'd0);
      check("rst_out_c", 32'(out_c), 32'd0);
      check("rst_out_ovf", 32'(out_ovf), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors, back-to-back, with exact latency checking.
      dir.push_back('{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0});
      dir.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
      dir.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
      dir.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0});
      dir.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
      dir.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
      dir.push_back('{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0});
      chk_lat = 1'b1;
      foreach (dir[i]) begin
         e.sum = dir[i].sum; e.c = dir[i].co; e.ovf = dir[i].ovf; e.cyc = 0;
         send(dir[i].a, dir[i].b, dir[i].c, dir[i].sub, e);
      end
      in_valid = 1'b0;
      drain();
      chk_lat = 1'b0;

      // Four accepted, then three cycles of backpressure.
      p0 = n_pop;
      for (int i = 0; i < 4; i++) begin
         ra = N'($urandom); rb = N'($urandom); rc = 1'($urandom); rs = 1'($urandom);
         send(ra, rb, rc, rs, model(ra, rb, rc, rs));
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();
      check("stall_count", 32'(n_pop - p0), 32'd4);

      // Corner operands and random stream under random backpressure and bubbles.
      corner = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};
      rand_rdy = 1'b1;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++)
            for (int k = 0; k < 4; k++)
               send(corner[i], corner[j], k[0], k[1], model(corner[i], corner[j], k[0], k[1]));
      for (int i = 0; i < 2000; i++) begin
         ra = N'($urandom); rb = N'($urandom); rc = 1'($urandom); rs = 1'($urandom);
         send(ra, rb, rc, rs, model(ra, rb, rc, rs));
         if ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;
      drain();
      rand_rdy  = 1'b0;
      out_ready = 1'b1;

      // Asynchronous reset with two results in flight.
      out_ready = 1'b0;
      p0 = n_pop;
      send(8'h11, 8'h22, 1'b0, 1'b0, model(8'h11, 8'h22, 1'b0, 1'b0));
      send(8'h33, 8'h44, 1'b0, 1'b0, model(8'h33, 8'h44, 1'b0, 1'b0));
      in_valid = 1'b0;
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_sum", 32'(out_sum), 32'd0);
      check("arst_c", 32'(out_c), 32'd0);
      check("arst_ovf", 32'(out_ovf), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      send(8'h5A, 8'h3C, 1'b1, 1'b1, model(8'h5A, 8'h3C, 1'b1, 1'b1));
      in_valid = 1'b0;
      drain();
      check("post_rst_count", 32'(n_pop - p0), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
